// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: header width, packet sizing and FSM states.
package spi_pkg;

  localparam int unsigned SpiHdrWidth = 4;

  function automatic int unsigned packet_size(input int unsigned param_width);
    return param_width + SpiHdrWidth;
  endfunction

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLow,
    StHigh,
    StGap,
    StHold,
    StDone
  } spi_state_e;

endpackage

// File: rtl/spi_bit_timer.sv
// Loadable down-counter; tc_o is high on the last cycle of a loaded interval.
module spi_bit_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module synchronizer #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/spi_master.sv
// SPI master: streams num_words packets from TX memory MSB first, writes received packets to RX
// memory. SSEL stays low across all packets of one transaction.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned ParamWidth = 36,
  parameter int unsigned AddrWidth  = 8,
  parameter int unsigned ClkDiv     = 4,
  parameter int unsigned GapCycles  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [AddrWidth:0]    num_words_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [AddrWidth-1:0]  tx_rd_addr_o,
  input  logic [ParamWidth-1:0] tx_rd_data_i,
  output logic [AddrWidth-1:0]  rx_wr_addr_o,
  output logic [ParamWidth-1:0] rx_wr_data_o,
  output logic                  rx_wr_enable_o,
  output logic                  spi_sclk_o,
  output logic                  spi_ssel_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
);

  localparam int unsigned PktSize     = packet_size(ParamWidth);
  localparam int unsigned BitCntWidth = $clog2(PktSize + 1);
  localparam int unsigned TmrMax      = (ClkDiv > GapCycles) ? ClkDiv : GapCycles;
  localparam int unsigned TmrWidth    = $clog2(TmrMax + 1);
  localparam logic [TmrWidth-1:0]    DivLoad = TmrWidth'(ClkDiv - 1);
  localparam logic [TmrWidth-1:0]    GapLoad = TmrWidth'(GapCycles - 1);
  localparam logic [BitCntWidth-1:0] BitLast = BitCntWidth'(PktSize - 1);

  spi_state_e             state_q, state_d;
  logic [PktSize-1:0]     tx_shift_q, tx_shift_d;
  // Only the low ParamWidth bits are kept; header bits shift out and are discarded.
  logic [ParamWidth-1:0]  rx_shift_q, rx_shift_d;
  logic [BitCntWidth-1:0] bit_cnt_q, bit_cnt_d;
  logic [AddrWidth:0]     word_idx_q, word_idx_d;
  logic [AddrWidth:0]     num_words_q, num_words_d;
  logic                   rx_we_q, rx_we_d;
  logic [AddrWidth-1:0]   rx_addr_q, rx_addr_d;
  logic [ParamWidth-1:0]  rx_data_q, rx_data_d;

  logic                tmr_load;
  logic [TmrWidth-1:0] tmr_val;
  logic                tmr_tc;
  logic                miso_sync;

  synchronizer #(
    .Stages(2)
  ) u_miso_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (spi_miso_i),
    .q_o   (miso_sync)
  );

  spi_bit_timer #(
    .Width(TmrWidth)
  ) u_bit_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .tc_o      (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    bit_cnt_d   = bit_cnt_q;
    word_idx_d  = word_idx_q;
    num_words_d = num_words_q;
    rx_we_d     = 1'b0;
    rx_addr_d   = '0;
    rx_data_d   = '0;
    tmr_load    = 1'b0;
    tmr_val     = DivLoad;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (num_words_i == '0) begin
            state_d = StDone;
          end else begin
            num_words_d = num_words_i;
            word_idx_d  = '0;
            tmr_load    = 1'b1;
            state_d     = StSetup;
          end
        end
      end
      // TX data has been valid since the second cycle of SETUP/GAP.
      StSetup, StGap: begin
        if (tmr_tc) begin
          tx_shift_d = {{SpiHdrWidth{1'b0}}, tx_rd_data_i};
          bit_cnt_d  = '0;
          tmr_load   = 1'b1;
          state_d    = StLow;
        end
      end
      StLow: begin
        if (tmr_tc) begin
          rx_shift_d = {rx_shift_q[ParamWidth-2:0], miso_sync};
          tmr_load   = 1'b1;
          state_d    = StHigh;
        end
      end
      StHigh: begin
        if (tmr_tc) begin
          tx_shift_d = tx_shift_q << 1;
          tmr_load   = 1'b1;
          if (bit_cnt_q == BitLast) begin
            rx_we_d    = 1'b1;
            rx_addr_d  = word_idx_q[AddrWidth-1:0];
            rx_data_d  = rx_shift_q;
            word_idx_d = word_idx_q + 1'b1;
            if (word_idx_d < num_words_q) begin
              tmr_val = GapLoad;
              state_d = StGap;
            end else begin
              state_d = StHold;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = StLow;
          end
        end
      end
      StHold: begin
        if (tmr_tc) begin
          word_idx_d = '0;
          state_d    = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      word_idx_q  <= '0;
      num_words_q <= '0;
      rx_we_q     <= 1'b0;
      rx_addr_q   <= '0;
      rx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      word_idx_q  <= word_idx_d;
      num_words_q <= num_words_d;
      rx_we_q     <= rx_we_d;
      rx_addr_q   <= rx_addr_d;
      rx_data_q   <= rx_data_d;
    end
  end

  assign busy_o         = !(state_q inside {StIdle, StDone});
  assign done_o         = (state_q == StDone);
  assign spi_ssel_o     = (state_q inside {StIdle, StDone});
  assign spi_sclk_o     = (state_q == StHigh);
  assign spi_mosi_o     = (state_q inside {StLow, StHigh}) & tx_shift_q[PktSize-1];
  assign tx_rd_addr_o   = word_idx_q[AddrWidth-1:0];
  assign rx_wr_addr_o   = rx_addr_q;
  assign rx_wr_data_o   = rx_data_q;
  assign rx_wr_enable_o = rx_we_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: cycle-level arithmetic model plus a behavioural SPI slave.
module tb_spi_master;

  localparam int PW  = 36;
  localparam int AW  = 8;
  localparam int CD  = 4;
  localparam int GP  = 8;
  localparam int PKT = PW + 4;
  localparam int W   = 2 * CD * PKT;
  localparam int PER = W + GP;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic          busy, done;
  logic [AW-1:0] tx_rd_addr, rx_wr_addr;
  logic [PW-1:0] tx_rd_data, rx_wr_data;
  logic          rx_we;
  logic          spi_sclk, spi_ssel, spi_mosi, spi_miso;

  always #5 clk = ~clk;

  spi_master #(
    .ParamWidth(PW),
    .AddrWidth (AW),
    .ClkDiv    (CD),
    .GapCycles (GP)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .start_i       (start),
    .num_words_i   (num_words),
    .busy_o        (busy),
    .done_o        (done),
    .tx_rd_addr_o  (tx_rd_addr),
    .tx_rd_data_i  (tx_rd_data),
    .rx_wr_addr_o  (rx_wr_addr),
    .rx_wr_data_o  (rx_wr_data),
    .rx_wr_enable_o(rx_we),
    .spi_sclk_o    (spi_sclk),
    .spi_ssel_o    (spi_ssel),
    .spi_mosi_o    (spi_mosi),
    .spi_miso_i    (spi_miso)
  );

  logic [PW-1:0] tx_mem [256];
  logic [PW-1:0] smem   [256];
  logic [PW-1:0] rx_cap [256];

  always @(posedge clk) tx_rd_data <= tx_mem[tx_rd_addr];

  int n_tests = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: preload zero, then memory word k after each packet; MISO changes on SCLK fall.
  logic           tie_one = 1'b1;
  logic [PKT-1:0] sl_out = '0;
  int             sl_cnt = 0, sl_k = 0;
  assign spi_miso = tie_one ? 1'b1 : sl_out[PKT-1];

  always @(negedge spi_sclk) begin
    sl_cnt++;
    if (sl_cnt == PKT) begin
      sl_cnt = 0;
      sl_out = {4'h0, smem[sl_k % 256]};
      sl_k++;
    end else begin
      sl_out = sl_out << 1;
    end
  end

  logic [PKT-1:0] mo_sr = '0;
  logic [PKT-1:0] mo_words[$];
  int mo_cnt = 0, sclk_pulses = 0, ssel_falls = 0, wr_count = 0;

  always @(posedge spi_sclk) begin
    sclk_pulses++;
    mo_sr = {mo_sr[PKT-2:0], spi_mosi};
    mo_cnt++;
    if (mo_cnt == PKT) begin
      mo_words.push_back(mo_sr);
      mo_cnt = 0;
    end
  end

  always @(negedge spi_ssel) ssel_falls++;

  bit txn_valid = 1'b0;
  int txn_start = 0, txn_n = 0;
  int hi_min = 1000, hi_max = 0, lo_max = 0, run = 0;
  logic prev_sclk = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Expected outputs at cycle offset c after the start edge, from the packet timing rules.
  function automatic void model(input int c, input int n, output bit sel, output bit sclk,
                                output bit bsy, output bit dn, output bit we,
                                output int word, output int bitn, output int wword);
    int e, r, k;
    sel = 0; sclk = 0; bsy = 0; dn = 0; we = 0; word = 0; bitn = 0; wword = 0;
    if (c < 0) return;
    if (n == 0) begin
      dn = (c == 0);
      return;
    end
    e = CD + (n - 1) * PER + W;
    if (c < e + CD) begin
      bsy = 1;
      sel = 1;
    end
    dn = (c == e + CD);
    if (c >= CD && c < e) begin
      k = (c - CD) / PER;
      r = (c - CD) % PER;
      if (r < W) begin
        word = k;
        bitn = r / (2 * CD);
        sclk = (r % (2 * CD)) >= CD;
      end
    end
    if (c >= CD + W) begin
      k = (c - CD - W) / PER;
      if ((c - CD - W) % PER == 0 && k < n) begin
        we = 1;
        wword = k;
      end
    end
  endfunction

  function automatic logic [PW-1:0] exp_rx(input int w);
    if (tie_one) return '1;
    if (w == 0) return '0;
    return smem[w-1];
  endfunction

  function automatic logic pkt_bit(input int w, input int b);
    logic [PKT-1:0] p;
    p = {4'h0, tx_mem[w]};
    return p[PKT-1-b];
  endfunction

  always @(negedge clk) begin
    int c, e_word, e_bit, e_wword;
    bit e_sel, e_sclk, e_busy, e_done, e_we;
    c = txn_valid ? cyc - txn_start : -1;
    model(c, txn_n, e_sel, e_sclk, e_busy, e_done, e_we, e_word, e_bit, e_wword);
    chk("ssel", spi_ssel, !e_sel);
    chk("sclk", spi_sclk, e_sclk);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("rx_we", rx_we, e_we);
    if (e_sclk) chk("mosi", spi_mosi, pkt_bit(e_word, e_bit));
    if (!e_sel) begin
      chk("mosi_idle", spi_mosi, 0);
      chk("tx_addr_idle", tx_rd_addr, 0);
      chk("rx_addr_idle", rx_wr_addr, 0);
    end
    if (e_we && rx_we) begin
      chk("rx_addr", rx_wr_addr, e_wword);
      chk("rx_data", rx_wr_data, exp_rx(e_wword));
    end
    if (rx_we) begin
      rx_cap[rx_wr_addr] = rx_wr_data;
      wr_count++;
    end
    if (!spi_ssel) begin
      if (spi_sclk == prev_sclk) begin
        run++;
      end else begin
        if (prev_sclk) begin
          if (run < hi_min) hi_min = run;
          if (run > hi_max) hi_max = run;
        end else if (run > lo_max) begin
          lo_max = run;
        end
        run = 1;
      end
    end else begin
      run = 0;
    end
    prev_sclk = spi_sclk;
  end

  task automatic clear_obs();
    sl_out = '0; sl_cnt = 0; sl_k = 0;
    mo_cnt = 0; mo_words.delete();
    sclk_pulses = 0; ssel_falls = 0; wr_count = 0;
    hi_min = 1000; hi_max = 0; lo_max = 0;
    foreach (rx_cap[i]) rx_cap[i] = '0;
  endtask

  task automatic start_txn(input int n);
    clear_obs();
    @(posedge clk); #1;
    start = 1'b1;
    num_words = (AW+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    txn_start = cyc;
    txn_n = n;
    txn_valid = 1'b1;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", done, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    txn_valid = 1'b0;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic rand_mems(input int n);
    for (int i = 0; i < n; i++) begin
      tx_mem[i] = {4'($urandom_range(0, 15)), $urandom()};
      smem[i]   = {4'($urandom_range(0, 15)), $urandom()};
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, k;
    foreach (tx_mem[i]) begin
      tx_mem[i] = '0;
      smem[i] = '0;
      rx_cap[i] = '0;
    end
    #2 do_reset();
    @(negedge clk);
    chk("rst_ssel", spi_ssel, 1);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", rx_we, 0);

    // Single word, MISO tied high.
    tie_one = 1'b1;
    tx_mem[0] = 36'h9_1234_5678;
    start_txn(1);
    wait_done(PER + 50);
    chk("t1_mosi_words", mo_words.size(), 1);
    if (mo_words.size() > 0) chk("t1_mosi_packet", mo_words[0], 40'h09_1234_5678);
    chk("t1_sclk_pulses", sclk_pulses, 40);
    chk("t1_writes", wr_count, 1);
    chk("t1_rx0", rx_cap[0], 36'hF_FFFF_FFFF);
    chk("t1_ssel_after", spi_ssel, 1);

    // Loopback through the slave model.
    tie_one = 1'b0;
    tx_mem[0] = 36'd1; tx_mem[1] = 36'd2; tx_mem[2] = 36'd3;
    smem[0] = 36'hAAA; smem[1] = 36'hBBB;
    start_txn(3);
    wait_done(3 * PER + 50);
    chk("t2_rx0", rx_cap[0], 36'h0);
    chk("t2_rx1", rx_cap[1], 36'hAAA);
    chk("t2_rx2", rx_cap[2], 36'hBBB);
    chk("t2_writes", wr_count, 3);
    chk("t2_ssel_falls", ssel_falls, 1);

    // Zero-length transaction.
    start_txn(0);
    wait_done(10);
    chk("t3_writes", wr_count, 0);
    chk("t3_sclk_pulses", sclk_pulses, 0);
    chk("t3_ssel_falls", ssel_falls, 0);

    // Asynchronous reset in the middle of bit 17 of word 1 of 4.
    rand_mems(4);
    start_txn(4);
    k = 0;
    while (cyc - txn_start != CD + PER + 17 * 2 * CD + CD && k < 2000) begin
      @(negedge clk);
      k++;
    end
    #1;
    txn_valid = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("ar_ssel", spi_ssel, 1);
    chk("ar_sclk", spi_sclk, 0);
    chk("ar_busy", busy, 0);
    chk("ar_we", rx_we, 0);
    repeat (3) @(negedge clk);
    #1 rst_ni = 1'b1;
    repeat (4) @(negedge clk);
    chk("ar_writes", wr_count, 1);
    start_txn(2);
    wait_done(2 * PER + 50);
    chk("ar_rerun_writes", wr_count, 2);
    chk("ar_rerun_rx0", rx_cap[0], 36'h0);
    chk("ar_rerun_rx1", rx_cap[1], smem[0]);

    // start and num_words disturbed while busy, and start coincident with DONE.
    tie_one = 1'b1;
    rand_mems(3);
    start_txn(3);
    k = 0;
    while (k < 3 * PER + 50) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) break;
      start = (k % 97 == 0);
      if (start) num_words = (AW+1)'($urandom_range(1, 9));
    end
    chk("md_done", done, 1);
    start = 1'b1;
    num_words = 9'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("md_writes", wr_count, 3);

    // Bit and gap timing, two words.
    tie_one = 1'b0;
    rand_mems(2);
    start_txn(2);
    wait_done(2 * PER + 50);
    chk("tm_high_min", hi_min, CD);
    chk("tm_high_max", hi_max, CD);
    chk("tm_low_max", lo_max, GP + CD);
    chk("tm_writes", wr_count, 2);

    // Randomized transactions.
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 4);
      tie_one = 1'($urandom_range(0, 1));
      rand_mems(n);
      start_txn(n);
      wait_done(n * PER + 50);
      chk("rnd_writes", wr_count, n);
      chk("rnd_mosi_words", mo_words.size(), n);
      for (int i = 0; i < n; i++) begin
        chk("rnd_rx", rx_cap[i], exp_rx(i));
        if (i < mo_words.size()) chk("rnd_mosi", mo_words[i], {4'h0, tx_mem[i]});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
